lr_shift_deserializer: RTL

Serial-in, parallel-out receiver that is the far end of the team's left/right shift register. It collects a serial bit stream shifted out MSB-first (left shift) or LSB-first (right shift) and reassembles WIDTH-bit words. Each completed word is presented on a one-entry valid/ready output buffer, with sticky overrun detection. It sits between a serial link and any parallel consumer.

---
 rtl/lr_shift_deserializer.sv | 101 ++++++++++
 1 files changed

// File: rtl/lr_shift_deserializer.sv
// Serial-in/parallel-out receiver for MSB-first or LSB-first frames of WIDTH bits,
// with a one-entry valid/ready output buffer and sticky overrun flag.
//
// state | meaning
// IDLE  | no frame in progress, bit_cnt = 0
// SHIFT | frame in progress, bit_cnt = 1..WIDTH-1
module lr_shift_deserializer #(
  parameter int WIDTH = 4,
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin_valid,
  input  logic             sin,
  input  logic             lr_bar,
  input  logic             clr,
  input  logic             y_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic             busy,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt, shifted, y_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             order, order_nxt, cur_order;
  logic             y_valid_nxt, overrun_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      order   <= 1'b0;
      y       <= '0;
      y_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= cnt_nxt;
      order   <= order_nxt;
      y       <= y_nxt;
      y_valid <= y_valid_nxt;
      overrun <= overrun_nxt;
    end
  end

  // The first bit of a frame uses the live lr_bar; later bits use the latched order.
  assign cur_order = (state == IDLE) ? lr_bar : order;
  assign shifted   = cur_order ? {sin, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], sin};
  assign busy      = (bit_cnt != '0);

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    cnt_nxt     = bit_cnt;
    order_nxt   = order;
    y_nxt       = y;
    y_valid_nxt = y_valid;
    overrun_nxt = overrun;

    if (y_valid && y_ready) y_valid_nxt = 1'b0;

    if (clr) begin
      state_nxt   = IDLE;
      shreg_nxt   = '0;
      cnt_nxt     = '0;
      overrun_nxt = 1'b0;
    end else if (sin_valid) begin
      shreg_nxt = shifted;
      case (state)
        IDLE: begin
          order_nxt = lr_bar;
          cnt_nxt   = CW'(1);
          state_nxt = SHIFT;
        end
        SHIFT: begin
          if (bit_cnt == CW'(WIDTH - 1)) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
            if (!y_valid || y_ready) begin
              y_nxt       = shifted;
              y_valid_nxt = 1'b1;
            end else begin
              overrun_nxt = 1'b1;
            end
          end else begin
            cnt_nxt = bit_cnt + CW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
